aes_inv_round: RTL



---
 rtl/aes_inv_round.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/aes_inv_round.sv
`timescale 1ns/1ps
// aes_inv_round: iterative AES inverse round (AddRoundKey, column-serial InvMixColumns,
// row-serial InvShiftRows+InvSubBytes). Build option AES_INV_SBOX_FROM_FWD_EN derives the inverse S-box from the forward table.
module aes_inv_round (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic [127:0] in_key,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IMC  = 2'd1,
      ISB  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t       state_reg, state_next;
   logic [127:0] st, st_next;
   logic [1:0]   cnt, cnt_next;
   logic         last_reg, last_next;

   logic [7:0]   inv_rom [256];
   logic [7:0]   col_a [4];
   logic [7:0]   col_b [4];
   logic [31:0]  row_in;
   logic [31:0]  row_new;

   // InvMixColumns coefficients for b0; row r uses them rotated right by r
   localparam logic [3:0] IMC_K [4] = '{4'he, 4'hb, 4'hd, 4'h9};

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] x2, x4, x8;
      x2 = xt(a);
      x4 = xt(x2);
      x8 = xt(x4);
      return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
             (k[1] ? x2 : 8'h00) ^ (k[0] ? a  : 8'h00);
   endfunction

`ifdef AES_INV_SBOX_FROM_FWD_EN
   localparam logic [2047:0] FWD_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };
   // The forward S-box is a permutation, so every inverse entry gets exactly one driver
   for (genvar gi = 0; gi < 256; gi++) begin : g_inv_rom
      assign inv_rom[FWD_SBOX[2047-8*gi -: 8]] = 8'(gi);
   end
`else
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };
   for (genvar gi = 0; gi < 256; gi++) begin : g_inv_rom
      assign inv_rom[gi] = INV_SBOX[2047-8*gi -: 8];
   end
`endif

   // Column cnt through InvMixColumns
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         col_a[r] = st[127-32*r-8*int'(cnt) -: 8];
      end
      for (int r = 0; r < 4; r++) begin
         col_b[r] = 8'h00;
         for (int j = 0; j < 4; j++) begin
            col_b[r] = col_b[r] ^ gmul(col_a[j], IMC_K[2'(j-r)]);
         end
      end
   end

   // Row cnt rotated right by cnt bytes, then substituted bytewise
   assign row_in = st[127-32*int'(cnt) -: 32];

   for (genvar gi = 0; gi < 4; gi++) begin : g_isb
      logic [1:0] src;
      assign src = 2'(gi) - cnt;
      assign row_new[31-8*gi -: 8] = inv_rom[row_in[31-8*int'(src) -: 8]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid) state_next = in_last ? ISB : IMC;
         IMC:     if (cnt == 2'd3) state_next = ISB;
         ISB:     if (cnt == 2'd3) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_reg == IDLE);
      out_valid = (state_reg == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= '0;
         cnt      <= 2'd0;
         last_reg <= 1'b0;
      end else begin
         st       <= st_next;
         cnt      <= cnt_next;
         last_reg <= last_next;
      end
   end

   always_comb begin
      st_next   = st;
      cnt_next  = cnt;
      last_next = last_reg;
      case (state_reg)
         IDLE: begin
            cnt_next = 2'd0;
            if (in_valid) begin
               st_next   = in_state ^ in_key;
               last_next = in_last;
            end
         end
         IMC: begin
            if (!last_reg) begin
               for (int r = 0; r < 4; r++) begin
                  st_next[127-32*r-8*int'(cnt) -: 8] = col_b[r];
               end
            end
            cnt_next = cnt + 2'd1;
         end
         ISB: begin
            st_next[127-32*int'(cnt) -: 32] = row_new;
            cnt_next = cnt + 2'd1;
         end
         default: ;
      endcase
   end

   assign out_state = st;

endmodule
